blur_window_ctrl: RTL

//  Front end of the 3x3 box blur. Accepts a raster pixel stream and stores rows in four rotating

---
 rtl/blur_window_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/blur_window_ctrl.sv
// blur_window_ctrl: line-buffer front end of the 3x3 box blur.
// Rows are written into four rotating line stores. Once three full rows are
// held, one 3x3 window per handshake is presented to the downstream kernel.
// The next row is written while the current three rows are read.
module blur_window_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   inPixel,
  input  logic                    inPixelValid,
  output logic                    inPixelReady,
  output logic [9*DATA_WIDTH-1:0] window,
  output logic                    windowValid,
  input  logic                    windowReady,
  output logic                    lineDone
);

  localparam int              AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [AW-1:0]   LAST_COL = AW'(IMG_WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

  logic [DATA_WIDTH-1:0] r_store [4][IMG_WIDTH];

  logic [1:0]    r_wrcur;
  logic [1:0]    r_rdcur;
  logic [AW-1:0] r_wrptr;
  logic [AW-1:0] r_rdptr;
  logic [2:0]    r_lines_held;
  logic [0:0]    r_state;
  logic          r_valid;
  logic          r_line_done;

  logic          w_wr;
  logic          w_rd;
  logic          w_wr_row_end;
  logic          w_rd_row_end;
  logic [1:0]    w_mid;
  logic [1:0]    w_bot;
  logic [AW-1:0] w_col1;
  logic [AW-1:0] w_col2;

  // Handshake qualifiers and row-boundary detection.
  always_comb begin
    inPixelReady = (r_lines_held < 3'd4);
    w_wr         = inPixelValid & inPixelReady;
    w_rd         = r_valid & windowReady;
    w_wr_row_end = w_wr & (r_wrptr == LAST_COL);
    w_rd_row_end = w_rd & (r_rdptr == LAST_COL);
  end

  // Line store write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_store[r_wrcur][r_wrptr] <= inPixel;
    end
  end

  // Write pointer and current write row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrptr <= '0;
      r_wrcur <= '0;
    end else if (w_wr) begin
      if (r_wrptr == LAST_COL) begin
        r_wrptr <= '0;
        r_wrcur <= r_wrcur + 2'd1;
      end else begin
        r_wrptr <= r_wrptr + 1'b1;
      end
    end
  end

  // Read pointer, current top row and the one-cycle lineDone pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdptr     <= '0;
      r_rdcur     <= '0;
      r_line_done <= 1'b0;
    end else begin
      r_line_done <= w_rd_row_end;
      if (w_rd) begin
        if (r_rdptr == LAST_COL) begin
          r_rdptr <= '0;
          r_rdcur <= r_rdcur + 2'd1;
        end else begin
          r_rdptr <= r_rdptr + 1'b1;
        end
      end
    end
  end

  // Count of complete rows held; a row finishing on each side at once cancels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lines_held <= '0;
    end else begin
      case ({w_wr_row_end, w_rd_row_end})
        2'b10:   r_lines_held <= r_lines_held + 3'd1;
        2'b01:   r_lines_held <= r_lines_held - 3'd1;
        default: r_lines_held <= r_lines_held;
      endcase
    end
  end

  // IDLE/READ control; windowValid trails entry into READ by one cycle, so
  // every row is preceded by at least one IDLE cycle and one setup cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (r_state == S_READ) & ~w_rd_row_end;
      case (r_state)
        S_IDLE:  if (r_lines_held >= 3'd3) r_state <= S_READ;
        S_READ:  if (w_rd_row_end)         r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tap addressing with column wrap, and window assembly gated by valid.
  always_comb begin
    w_mid  = r_rdcur + 2'd1;
    w_bot  = r_rdcur + 2'd2;
    w_col1 = (r_rdptr == LAST_COL) ? '0 : r_rdptr + 1'b1;
    w_col2 = (w_col1  == LAST_COL) ? '0 : w_col1  + 1'b1;
    window = '0;
    if (r_valid) begin
      window = {r_store[r_rdcur][r_rdptr], r_store[r_rdcur][w_col1], r_store[r_rdcur][w_col2],
                r_store[w_mid][r_rdptr],   r_store[w_mid][w_col1],   r_store[w_mid][w_col2],
                r_store[w_bot][r_rdptr],   r_store[w_bot][w_col1],   r_store[w_bot][w_col2]};
    end
  end

  assign windowValid = r_valid;
  assign lineDone    = r_line_done;

endmodule
